add64_pipe: RTL

//  Two-stage pipelined 64-bit adder that consumes operand pairs and emits registered sums.

---
 rtl/add64_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/add64_pipe.sv
// add64_pipe: two-stage valid/ready pipelined adder, low half with cin in stage 1, high half in stage 2.
module add64_pipe #(
    parameter int HALF_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF_W-1:0] operand1,
    input  logic [2*HALF_W-1:0] operand2,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] result,
    output logic                cout1,
    output logic                cout2,
    output logic                ovf,
    output logic [CNT_W-1:0]    done_cnt
);
    localparam int W = 2 * HALF_W;

    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [HALF_W-1:0] lo_sum_q, lo_sum_d, a_hi_q, a_hi_d, b_hi_q, b_hi_d;
    logic              c1_q, c1_d;
    logic [W-1:0]      result_q, result_d;
    logic              cout1_q, cout1_d, cout2_q, cout2_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
    logic              s2_free, s1_adv, accept;
    logic [HALF_W:0]   lo_add, hi_add;

    always_comb begin
        s2_free    = !s2_valid_q | out_ready;
        s1_adv     = s1_valid_q & s2_free;
        in_ready   = !s1_valid_q | s2_free;
        accept     = in_valid & in_ready;
        lo_add     = {1'b0, operand1[HALF_W-1:0]} + {1'b0, operand2[HALF_W-1:0]} + {{HALF_W{1'b0}}, cin};
        hi_add     = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{HALF_W{1'b0}}, c1_q};
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        lo_sum_d   = accept ? lo_add[HALF_W-1:0] : lo_sum_q;
        c1_d       = accept ? lo_add[HALF_W] : c1_q;
        a_hi_d     = accept ? operand1[W-1:HALF_W] : a_hi_q;
        b_hi_d     = accept ? operand2[W-1:HALF_W] : b_hi_q;
        // stage 2 keeps its data on a bubble; only the valid bit drops
        s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
        result_d   = s1_adv ? {hi_add[HALF_W-1:0], lo_sum_q} : result_q;
        cout1_d    = s1_adv ? c1_q : cout1_q;
        cout2_d    = s1_adv ? hi_add[HALF_W] : cout2_q;
        ovf_d      = s1_adv ? (a_hi_q[HALF_W-1] == b_hi_q[HALF_W-1]) & (hi_add[HALF_W-1] != a_hi_q[HALF_W-1]) : ovf_q;
        done_cnt_d = done_cnt_q + CNT_W'(s2_valid_q & out_ready);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            lo_sum_q   <= '0;
            c1_q       <= 1'b0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            result_q   <= '0;
            cout1_q    <= 1'b0;
            cout2_q    <= 1'b0;
            ovf_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            lo_sum_q   <= lo_sum_d;
            c1_q       <= c1_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            result_q   <= result_d;
            cout1_q    <= cout1_d;
            cout2_q    <= cout2_d;
            ovf_q      <= ovf_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign cout1     = cout1_q;
    assign cout2     = cout2_q;
    assign ovf       = ovf_q;
    assign done_cnt  = done_cnt_q;
endmodule
